// File: rtl/pacote_registradores.sv
// Shared command codes and multiply FSM states for the X/Y/Z register datapath.
package pacote_registradores;

  localparam logic [3:0] CMD_CLEAR  = 4'd0;
  localparam logic [3:0] CMD_LOAD   = 4'd1;
  localparam logic [3:0] CMD_HOLD   = 4'd2;
  localparam logic [3:0] CMD_SHIFTR = 4'd3;
  localparam logic [3:0] CMD_SHIFTL = 4'd4;
  localparam logic [3:0] CMD_SUB    = 4'd5;
  localparam logic [3:0] CMD_MULT   = 4'd6;

  typedef enum logic {
    OCIOSO,
    MULTIPLICANDO
  } estado_t;

endpackage

// File: rtl/multiplicador_serial.sv
// Serial unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
module multiplicador_serial
  import pacote_registradores::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               inicio,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] produto,
  output logic               ocupado,
  output logic               pronto,
  output logic               concluindo
);

  localparam int CW = $clog2(WIDTH + 1);

  estado_t              estado, estado_prox;
  logic [WIDTH-1:0]     mcand, mplier, mplier_passo;
  logic [2*WIDTH-1:0]   prod, prod_passo;
  logic [CW-1:0]        contador;
  logic [WIDTH:0]       soma;
  logic [3*WIDTH-1:0]   desloc;

  // One shift-add step; the top samples produto on the final step, so it is the step result.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    estado_prox = estado;
    concluindo  = 1'b0;
    soma        = {1'b0, prod[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    desloc      = {soma, prod[WIDTH-1:0], mplier[WIDTH-1:1]};
    prod_passo  = desloc[3*WIDTH-1:WIDTH];
    mplier_passo = desloc[WIDTH-1:0];
    case (estado)
      OCIOSO:        if (inicio) estado_prox = MULTIPLICANDO;
      MULTIPLICANDO: if (contador == CW'(1)) begin
        estado_prox = OCIOSO;
        concluindo  = 1'b1;
      end
      default:       estado_prox = OCIOSO;
    endcase
  end

  assign produto = prod_passo;
  assign ocupado = (estado == MULTIPLICANDO);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado   <= OCIOSO;
      pronto   <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      contador <= '0;
    end else begin
      estado <= estado_prox;
      pronto <= concluindo;
      if (estado == OCIOSO && inicio) begin
        mcand    <= multiplicand;
        mplier   <= multiplier;
        prod     <= '0;
        contador <= CW'(WIDTH);
      end else if (estado == MULTIPLICANDO) begin
        prod     <= prod_passo;
        mplier   <= mplier_passo;
        contador <= contador - CW'(1);
      end
    end
  end

endmodule

// File: rtl/registradores_xyz.sv
// X/Y/Z register datapath: X loads/shifts, Y accumulates (add/sub/shift/multiply), Z latches Y.
module registradores_xyz
  import pacote_registradores::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] entrada,
  input  logic [3:0]       tx,
  input  logic [3:0]       ty,
  input  logic [3:0]       tz,
  output logic [WIDTH-1:0] barramentodados,
  output logic [WIDTH-1:0] acumulador,
  output logic [WIDTH-1:0] saida,
  output logic             carry,
  output logic             zero,
  output logic             ocupado,
  output logic             pronto
);

  logic [WIDTH-1:0]   x_prox, y_prox, z_prox;
  logic               carry_prox, inicio, concluindo;
  logic [WIDTH:0]     soma, diferenca;
  logic [2*WIDTH-1:0] produto;

  assign inicio = (ty == CMD_MULT) && !ocupado;

  multiplicador_serial #(.WIDTH(WIDTH)) u_mult (
    .clock        (clock),
    .reset_n      (reset_n),
    .inicio       (inicio),
    .multiplicand (barramentodados),
    .multiplier   (acumulador),
    .produto      (produto),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .concluindo   (concluindo)
  );

  assign soma      = {1'b0, acumulador} + {1'b0, barramentodados};
  assign diferenca = {1'b0, acumulador} - {1'b0, barramentodados};

  always_comb begin
    x_prox     = barramentodados;
    y_prox     = acumulador;
    z_prox     = saida;
    carry_prox = carry;
    if (concluindo) begin
      y_prox     = produto[WIDTH-1:0];
      carry_prox = |produto[2*WIDTH-1:WIDTH];
    end else if (!ocupado) begin
      case (tx)
        CMD_CLEAR:  x_prox = '0;
        CMD_LOAD:   x_prox = entrada;
        CMD_SHIFTR: x_prox = barramentodados >> 1;
        CMD_SHIFTL: x_prox = barramentodados << 1;
        default:    x_prox = barramentodados;
      endcase
      case (ty)
        CMD_CLEAR:  begin y_prox = '0;                       carry_prox = 1'b0;                  end
        CMD_LOAD:   begin y_prox = soma[WIDTH-1:0];          carry_prox = soma[WIDTH];           end
        CMD_SUB:    begin y_prox = diferenca[WIDTH-1:0];     carry_prox = diferenca[WIDTH];      end
        CMD_SHIFTR: begin y_prox = acumulador >> 1;          carry_prox = acumulador[0];         end
        CMD_SHIFTL: begin y_prox = acumulador << 1;          carry_prox = acumulador[WIDTH-1];   end
        default:    ;
      endcase
      case (tz)
        CMD_CLEAR: z_prox = '0;
        CMD_LOAD:  z_prox = acumulador;
        default:   z_prox = saida;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      barramentodados <= '0;
      acumulador      <= '0;
      saida           <= '0;
      carry           <= 1'b0;
    end else begin
      barramentodados <= x_prox;
      acumulador      <= y_prox;
      saida           <= z_prox;
      carry           <= carry_prox;
    end
  end

  assign zero = (acumulador == '0);

endmodule

// File: tb/tb_registradores_xyz.sv
// Directed bench for registradores_xyz (WIDTH=4) with hand-computed expected values.
module tb_registradores_xyz;
  import pacote_registradores::*;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] entrada = '0;
  logic [3:0] tx = CMD_HOLD, ty = CMD_HOLD, tz = CMD_HOLD;
  logic [3:0] barramentodados, acumulador, saida;
  logic       carry, zero, ocupado, pronto;

  int n_cmp = 0;
  int n_err = 0;

  registradores_xyz #(.WIDTH(4)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .entrada         (entrada),
    .tx              (tx),
    .ty              (ty),
    .tz              (tz),
    .barramentodados (barramentodados),
    .acumulador      (acumulador),
    .saida           (saida),
    .carry           (carry),
    .zero            (zero),
    .ocupado         (ocupado),
    .pronto          (pronto)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cmd(input logic [3:0] cx, input logic [3:0] cy, input logic [3:0] cz,
                     input logic [3:0] dado);
    @(negedge clock);
    tx = cx; ty = cy; tz = cz; entrada = dado;
    @(posedge clock);
    #1;
  endtask

  task automatic check_xyz(input string tag, input int x, input int y, input int z, input int c);
    check({tag, ".x"}, 32'(barramentodados), x);
    check({tag, ".y"}, 32'(acumulador), y);
    check({tag, ".z"}, 32'(saida), z);
    check({tag, ".carry"}, 32'(carry), c);
    check({tag, ".zero"}, 32'(zero), (y == 0) ? 1 : 0);
  endtask

  // Called right after the accepting edge; drives bx/bz during busy cycles to prove they are ignored.
  task automatic run_mult(input string tag, input logic [3:0] bx, input logic [3:0] bz,
                          input logic [3:0] dado, input int exp_y, input int exp_c);
    int  ciclos;
    bit  fim;
    ciclos = 1;
    fim    = 1'b0;
    check({tag, ".busy0"}, 32'(ocupado), 1);
    for (int i = 0; i < 20 && !fim; i++) begin
      @(negedge clock);
      tx = bx; ty = CMD_HOLD; tz = bz; entrada = dado;
      @(posedge clock);
      #1;
      if (ocupado) begin
        ciclos++;
        check({tag, ".no_early_pronto"}, 32'(pronto), 0);
      end else begin
        fim = 1'b1;
      end
    end
    check({tag, ".finished"}, 32'(fim), 1);
    check({tag, ".busy_cycles"}, 32'(ciclos), 4);
    check({tag, ".pronto"}, 32'(pronto), 1);
    check({tag, ".y"}, 32'(acumulador), exp_y);
    check({tag, ".carry"}, 32'(carry), exp_c);
    check({tag, ".zero"}, 32'(zero), (exp_y == 0) ? 1 : 0);
    cmd(CMD_HOLD, CMD_HOLD, CMD_HOLD, 4'd0);
    check({tag, ".pronto_drop"}, 32'(pronto), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit viu_pronto;

    #12 reset_n = 1'b1;

    // Reset: load 7 everywhere, then assert reset mid-cycle
    cmd(CMD_LOAD, CMD_CLEAR, CMD_CLEAR, 4'd7);
    cmd(CMD_HOLD, CMD_LOAD, CMD_HOLD, 4'd0);
    cmd(CMD_HOLD, CMD_HOLD, CMD_LOAD, 4'd0);
    check_xyz("preset", 7, 7, 7, 0);
    #2 reset_n = 1'b0;
    #1;
    check_xyz("reset", 0, 0, 0, 0);
    check("reset.ocupado", 32'(ocupado), 0);
    check("reset.pronto", 32'(pronto), 0);
    #1 reset_n = 1'b1;

    // Add with carry
    cmd(CMD_LOAD, CMD_CLEAR, CMD_CLEAR, 4'd9);
    cmd(CMD_HOLD, CMD_LOAD, CMD_HOLD, 4'd0);
    check_xyz("add1", 9, 9, 0, 0);
    cmd(CMD_HOLD, CMD_LOAD, CMD_HOLD, 4'd0);
    check_xyz("add2", 9, 2, 0, 1);
    cmd(CMD_HOLD, CMD_HOLD, CMD_LOAD, 4'd0);
    check_xyz("zload", 9, 2, 2, 1);
    cmd(4'd15, 4'd15, 4'd15, 4'd3);
    check_xyz("undef_hold", 9, 2, 2, 1);

    // Subtract and shifts; Y=3 comes from adding the old X while X loads 5
    cmd(CMD_LOAD, CMD_CLEAR, CMD_HOLD, 4'd3);
    cmd(CMD_LOAD, CMD_LOAD, CMD_HOLD, 4'd5);
    check_xyz("sub_setup", 5, 3, 2, 0);
    cmd(CMD_HOLD, CMD_SUB, CMD_HOLD, 4'd0);
    check_xyz("sub", 5, 14, 2, 1);
    cmd(CMD_HOLD, CMD_SHIFTR, CMD_HOLD, 4'd0);
    check_xyz("shr", 5, 7, 2, 0);
    cmd(CMD_HOLD, CMD_SHIFTL, CMD_HOLD, 4'd0);
    check_xyz("shl1", 5, 14, 2, 0);
    cmd(CMD_HOLD, CMD_SHIFTL, CMD_HOLD, 4'd0);
    check_xyz("shl2", 5, 12, 2, 1);
    cmd(CMD_SHIFTL, CMD_HOLD, CMD_HOLD, 4'd0);
    check_xyz("x_shl", 10, 12, 2, 1);
    cmd(CMD_SHIFTR, CMD_HOLD, CMD_HOLD, 4'd0);
    check_xyz("x_shr", 5, 12, 2, 1);
    cmd(CMD_CLEAR, CMD_HOLD, CMD_CLEAR, 4'd0);
    check_xyz("xz_clear", 0, 12, 0, 1);
    cmd(CMD_HOLD, CMD_HOLD, CMD_LOAD, 4'd0);

    // Multiply 3*5 = 15
    cmd(CMD_LOAD, CMD_CLEAR, CMD_HOLD, 4'd5);
    cmd(CMD_LOAD, CMD_LOAD, CMD_HOLD, 4'd3);
    check_xyz("mul1_setup", 3, 5, 12, 0);
    cmd(CMD_HOLD, CMD_MULT, CMD_HOLD, 4'd0);
    run_mult("mul1", CMD_HOLD, CMD_HOLD, 4'd0, 15, 0);

    // Multiply 6*7 = 42 -> Y=10, overflow; X load and Z clear during busy are ignored
    cmd(CMD_LOAD, CMD_CLEAR, CMD_HOLD, 4'd7);
    cmd(CMD_LOAD, CMD_LOAD, CMD_HOLD, 4'd6);
    check_xyz("mul2_setup", 6, 7, 12, 0);
    cmd(CMD_HOLD, CMD_MULT, CMD_HOLD, 4'd0);
    run_mult("mul2", CMD_LOAD, CMD_CLEAR, 4'd15, 10, 1);
    check("mul2.x_frozen", 32'(barramentodados), 6);
    check("mul2.z_frozen", 32'(saida), 12);

    // Multiply of the old X while X loads on the accepting edge: 6*10 = 60 -> Y=12, carry 1
    cmd(CMD_LOAD, CMD_MULT, CMD_HOLD, 4'd1);
    check("mul3.x_loaded", 32'(barramentodados), 1);
    run_mult("mul3", CMD_HOLD, CMD_HOLD, 4'd0, 12, 1);

    // Abort: reset on the second busy cycle
    cmd(CMD_LOAD, CMD_CLEAR, CMD_HOLD, 4'd3);
    cmd(CMD_HOLD, CMD_LOAD, CMD_HOLD, 4'd0);
    cmd(CMD_HOLD, CMD_MULT, CMD_HOLD, 4'd0);
    check("abort.busy0", 32'(ocupado), 1);
    cmd(CMD_HOLD, CMD_HOLD, CMD_HOLD, 4'd0);
    check("abort.busy1", 32'(ocupado), 1);
    #2 reset_n = 1'b0;
    #1;
    check("abort.ocupado", 32'(ocupado), 0);
    check("abort.y", 32'(acumulador), 0);
    check("abort.zero", 32'(zero), 1);
    #1 reset_n = 1'b1;
    viu_pronto = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd(CMD_HOLD, CMD_HOLD, CMD_HOLD, 4'd0);
      if (pronto) viu_pronto = 1'b1;
    end
    check("abort.no_pronto", 32'(viu_pronto), 0);
    check("abort.y_after", 32'(acumulador), 0);

    // Same-edge reads: X=2, Y=4 then load X, add, latch Z together
    cmd(CMD_LOAD, CMD_CLEAR, CMD_CLEAR, 4'd2);
    cmd(CMD_HOLD, CMD_LOAD, CMD_HOLD, 4'd0);
    cmd(CMD_HOLD, CMD_LOAD, CMD_HOLD, 4'd0);
    check_xyz("same_setup", 2, 4, 0, 0);
    cmd(CMD_LOAD, CMD_LOAD, CMD_LOAD, 4'd5);
    check_xyz("same_edge", 5, 6, 4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
